i2c_mem_slave: RTL and testbench

Clocked I2C target (slave) that consumes the `scl`/`sda` pair produced by the team's I2C EEPROM master and backs it with a 128-byte memory. It oversamples both lines on the system clock, detects START/STOP, and decodes an address/R-W byte. It then either writes incoming bytes into memory or shifts memory bytes back onto `sda`, with address auto-increment. It also drives a dedicated `ack` output so the master's `ack` input can be wired directly.

---
 rtl/i2c_mem_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_mem_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_slave.sv
// I2C target backed by a 2^MEM_AW byte memory, LSB-first bytes, address auto-increment.
// Define I2C_SLV_SDA_ACK_EN to also drive the acknowledge bit onto sda during write/address ACK.
module i2c_mem_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              ack,
  output logic              busy,
  output logic              wr_stb,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WDATA     = 3'd3;
  localparam logic [2:0] WDATA_ACK = 3'd4;
  localparam logic [2:0] RDATA     = 3'd5;
  localparam logic [2:0] RDATA_ACK = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_p_q, sda_p_q;
  logic                   scl_s, sda_s;
  logic                   rise, fall, start_det, stop_det;

  logic [2:0]        state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic              rw_q, rw_d;
  logic              rdone_q, rdone_d;
  logic              sda_oe_q, sda_oe_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              wr_stb_q, wr_stb_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        new_byte;
  logic              mem_we;

  logic [7:0] mem_q [2**MEM_AW];

  // Synchronizers idle high so reset itself never manufactures a START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign rise      = scl_s & ~scl_p_q;
  assign fall      = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign new_byte  = {sda_p_q, shift_q[7:1]};
  assign ptr_inc   = ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    rdone_d   = rdone_q;
    sda_oe_d  = sda_oe_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      ack_d    = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = 3'd0;
      rdone_d  = 1'b0;
      sda_oe_d = 1'b0;
      ack_d    = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (rise) begin
            shift_d  = new_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = ADDR_ACK;
              ack_d   = 1'b1;
              ptr_d   = MEM_AW'(new_byte[7:1]);
              rw_d    = new_byte[0];
            end
          end
        end
        ADDR_ACK: begin
          if (rise) begin
            ack_d    = 1'b0;
            bitcnt_d = 3'd0;
            rdone_d  = 1'b0;
            if (rw_q) begin
              state_d = WDATA;
            end else begin
              state_d = RDATA;
              shift_d = mem_q[ptr_q];
            end
          end
`ifdef I2C_SLV_SDA_ACK_EN
          else if (fall) sda_oe_d = 1'b1;
`endif
        end
        WDATA: begin
          if (rise) begin
            shift_d  = new_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d   = WDATA_ACK;
              mem_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = new_byte;
              ack_d     = 1'b1;
            end
          end else if (fall) begin
            sda_oe_d = 1'b0;
          end
        end
        WDATA_ACK: begin
          if (rise) begin
            state_d  = WDATA;
            ack_d    = 1'b0;
            ptr_d    = ptr_inc;
            bitcnt_d = 3'd0;
          end
`ifdef I2C_SLV_SDA_ACK_EN
          else if (fall) sda_oe_d = 1'b1;
`endif
        end
        // Read bits are indexed in place; rdone marks that the 8th rise has passed.
        RDATA: begin
          if (rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) rdone_d = 1'b1;
          end else if (fall) begin
            if (rdone_q) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d = ~shift_q[bitcnt_q];
            end
          end
        end
        RDATA_ACK: begin
          if (rise) begin
            if (!sda_p_q) begin
              state_d  = RDATA;
              ptr_d    = ptr_inc;
              shift_d  = mem_q[ptr_inc];
              bitcnt_d = 3'd0;
              rdone_d  = 1'b0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'd0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      rdone_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      rdone_q   <= rdone_d;
      sda_oe_q  <= sda_oe_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[ptr_q] <= new_byte;
  end

  assign sda_oe  = sda_oe_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: bit-banged master with open-drain sda, scoreboard queues for writes and reads.
// Honours I2C_SLV_SDA_ACK_EN for the on-wire acknowledge expectation.
module tb_i2c_mem_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaLine;
  logic       sda_oe, ack, busy, wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

`ifdef I2C_SLV_SDA_ACK_EN
  localparam logic EXP_ACK_OE = 1'b1;
`else
  localparam logic EXP_ACK_OE = 1'b0;
`endif

  assign sdaLine = sdaM & ~sda_oe;

  i2c_mem_slave #(.SYNC_STAGES(2), .MEM_AW(7)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sdaLine),
    .sda_oe(sda_oe), .ack(ack), .busy(busy), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         wrCount = 0;
  int         ackCount = 0;
  int         oeCount = 0;
  logic       ackPrev = 1'b0;
  logic [6:0] obsAddr [64];
  logic [7:0] obsData [64];
  logic [14:0] expWr [$];
  logic [7:0]  expRd [$];
  int         rdIdx = 0;
  logic       ackOe = 1'b0;

  // Records every write strobe, ack rising edge and sda_oe cycle for later scoreboard checks.
  always @(negedge clk) begin
    ackPrev <= ack;
    if (ack === 1'b1 && ackPrev === 1'b0) ackCount <= ackCount + 1;
    if (sda_oe === 1'b1) oeCount <= oeCount + 1;
    if (wr_stb === 1'b1) begin
      obsAddr[wrCount % 64] <= wr_addr;
      obsData[wrCount % 64] <= wr_data;
      wrCount <= wrCount + 1;
    end
  end

  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic b);
    scl = 1'b0; waitClks(4);
    sdaM = b;   waitClks(4);
    scl = 1'b1; waitClks(8);
  endtask

  task automatic startCond();
    sdaM = 1'b0; waitClks(8);
  endtask

  task automatic repStart();
    scl = 1'b0;  waitClks(4);
    sdaM = 1'b1; waitClks(4);
    scl = 1'b1;  waitClks(8);
    sdaM = 1'b0; waitClks(8);
  endtask

  task automatic stopCond();
    scl = 1'b0;  waitClks(4);
    sdaM = 1'b0; waitClks(4);
    scl = 1'b1;  waitClks(8);
    sdaM = 1'b1; waitClks(8);
  endtask

  task automatic sendBits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(v[i]);
  endtask

  task automatic sendByte(input logic [7:0] v);
    sendBits(v, 8);
    scl = 1'b0;  waitClks(4);
    sdaM = 1'b1; waitClks(4);
    scl = 1'b1;  waitClks(4);
    ackOe = sda_oe;
    waitClks(4);
  endtask

  task automatic readCheck(input logic ackBit);
    logic [7:0] v;
    logic [7:0] e;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      scl = 1'b0;  waitClks(4);
      sdaM = 1'b1; waitClks(4);
      scl = 1'b1;  waitClks(4);
      v[i] = sdaLine;
      waitClks(4);
    end
    applyStimulus(ackBit);
    e = expRd.pop_front();
    checkOutput("rd_data", {24'd0, v}, {24'd0, e});
  endtask

  task automatic drainWrites();
    logic [14:0] e;
    while (rdIdx < wrCount) begin
      checks++;
      assert (expWr.size() != 0) else begin
        errors++;
        $error("[TB] FAIL wr_unexpected observed addr=0x%0h data=0x%0h expected no write",
               obsAddr[rdIdx % 64], obsData[rdIdx % 64]);
      end
      if (expWr.size() != 0) begin
        e = expWr.pop_front();
        checkOutput("wr_addr", {25'd0, obsAddr[rdIdx % 64]}, {25'd0, e[14:8]});
        checkOutput("wr_data", {24'd0, obsData[rdIdx % 64]}, {24'd0, e[7:0]});
      end
      rdIdx++;
    end
    checkOutput("wr_pending", expWr.size(), 0);
  endtask

  initial begin
    int a0, w0, o0;
    waitClks(4);
    checkOutput("rst_sda_oe", {31'd0, sda_oe}, 0);
    checkOutput("rst_ack", {31'd0, ack}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_wr_stb", {31'd0, wr_stb}, 0);
    checkOutput("rst_wr_addr", {25'd0, wr_addr}, 0);
    checkOutput("rst_wr_data", {24'd0, wr_data}, 0);
    rst = 1'b0;
    waitClks(4);

    $display("[TB] single byte write");
    expWr.push_back({7'h52, 8'h3C});
    a0 = ackCount; w0 = wrCount; o0 = oeCount;
    startCond();
    checkOutput("busy_after_start", {31'd0, busy}, 1);
    sendByte(8'hA5);
    sendByte(8'h3C);
    checkOutput("ack_oe_data", {31'd0, ackOe}, {31'd0, EXP_ACK_OE});
    stopCond();
    checkOutput("busy_after_stop", {31'd0, busy}, 0);
    checkOutput("ack_pulses", ackCount - a0, 2);
    checkOutput("wr_count_single", wrCount - w0, 1);
`ifndef I2C_SLV_SDA_ACK_EN
    checkOutput("oe_quiet_write", oeCount - o0, 0);
`endif
    drainWrites();

    $display("[TB] burst write with wrap");
    expWr.push_back({7'h7F, 8'h11});
    expWr.push_back({7'h00, 8'h22});
    startCond();
    sendByte(8'hFF);
    sendByte(8'h11);
    sendByte(8'h22);
    stopCond();
    drainWrites();

    $display("[TB] preload and read");
    expWr.push_back({7'h10, 8'h96});
    expWr.push_back({7'h11, 8'h5A});
    startCond();
    sendByte(8'h21);
    sendByte(8'h96);
    sendByte(8'h5A);
    stopCond();
    drainWrites();
    expRd.push_back(8'h96);
    expRd.push_back(8'h5A);
    startCond();
    sendByte(8'h20);
    readCheck(1'b0);
    readCheck(1'b1);
    waitClks(8);
    checkOutput("oe_wait_stop", {31'd0, sda_oe}, 0);
    checkOutput("busy_wait_stop", {31'd0, busy}, 1);
    stopCond();
    expRd.push_back(8'h11);
    expRd.push_back(8'h22);
    startCond();
    sendByte(8'hFE);
    readCheck(1'b0);
    readCheck(1'b1);
    stopCond();

    $display("[TB] repeated start mid-byte");
    expWr.push_back({7'h05, 8'hFF});
    w0 = wrCount;
    startCond();
    sendByte(8'h61);
    sendBits(8'hAA, 4);
    repStart();
    sendByte(8'h0B);
    sendByte(8'hFF);
    stopCond();
    checkOutput("wr_count_rstart", wrCount - w0, 1);
    drainWrites();

    $display("[TB] sync reset mid-read");
    startCond();
    sendByte(8'h20);
    scl = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sda_oe === 1'b1) break;
      waitClks(1);
    end
    checkOutput("oe_driven_before_rst", {31'd0, sda_oe}, 1);
    rst = 1'b1;
    waitClks(1);
    checkOutput("rst_mid_sda_oe", {31'd0, sda_oe}, 0);
    checkOutput("rst_mid_ack", {31'd0, ack}, 0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    a0 = ackCount; w0 = wrCount; o0 = oeCount;
    waitClks(4);
    scl = 1'b1; waitClks(8);
    sendBits(8'h5A, 8);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("post_rst_busy", {31'd0, busy}, 0);
    checkOutput("post_rst_ack", ackCount - a0, 0);
    checkOutput("post_rst_wr", wrCount - w0, 0);
    checkOutput("post_rst_oe", oeCount - o0, 0);
    expWr.push_back({7'h01, 8'hC3});
    startCond();
    sendByte(8'h03);
    sendByte(8'hC3);
    stopCond();
    drainWrites();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
